// File: rtl/hazard_scoreboard_if.sv
// Issue/forwarding bundle between the ID stage and the hazard scoreboard.
// The ID stage drives the sb_i_* side; the scoreboard drives the sb_o_* side.
interface hazard_scoreboard_if #(
    parameter int AWIDTH = 5,
    parameter int NREG   = 2**AWIDTH
);
    logic              sb_i_issue_valid;
    logic [AWIDTH-1:0] sb_i_issue_rd;
    logic              sb_i_issue_regwrite;
    logic              sb_i_issue_load;
    logic [AWIDTH-1:0] sb_i_rs1;
    logic [AWIDTH-1:0] sb_i_rs2;
    logic              sb_i_stall;
    logic              sb_i_flush;
    logic              sb_o_stall;
    logic [1:0]        sb_o_control_rs1;
    logic [1:0]        sb_o_control_rs2;
    logic [NREG-1:0]   sb_o_pending;

    modport master (
        output sb_i_issue_valid, sb_i_issue_rd, sb_i_issue_regwrite, sb_i_issue_load,
        output sb_i_rs1, sb_i_rs2, sb_i_stall, sb_i_flush,
        input  sb_o_stall, sb_o_control_rs1, sb_o_control_rs2, sb_o_pending
    );

    modport slave (
        input  sb_i_issue_valid, sb_i_issue_rd, sb_i_issue_regwrite, sb_i_issue_load,
        input  sb_i_rs1, sb_i_rs2, sb_i_stall, sb_i_flush,
        output sb_o_stall, sb_o_control_rs1, sb_o_control_rs2, sb_o_pending
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pipeline-position scoreboard: tracks in-flight writers through
// EX/MEM/WB, raises the load-use stall and registers forwarding selects for EX.
`ifndef AWIDTH
`define AWIDTH 5
`endif

module hazard_scoreboard #(
    parameter int AWIDTH = `AWIDTH,
    parameter int NREG   = 2**AWIDTH
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  sb
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EX   = 2'd1,
        S_MEM  = 2'd2,
        S_WB   = 2'd3
    } state_e;

    state_e     r_state [NREG];
    logic       r_load  [NREG];
    state_e     w_state_nxt [NREG];
    logic       w_load_nxt  [NREG];
    logic [1:0] r_ctrl_rs1;
    logic [1:0] r_ctrl_rs2;
    logic [1:0] w_ctrl_rs1;
    logic [1:0] w_ctrl_rs2;
    logic       w_use1;
    logic       w_use2;
    logic       w_stall;
    logic       w_issue_write;

    // Load-use hazard: a source is produced by a load that is still in EX.
    always_comb begin
        w_use1  = (sb.sb_i_rs1 != '0) && (r_state[sb.sb_i_rs1] == S_EX) && r_load[sb.sb_i_rs1];
        w_use2  = (sb.sb_i_rs2 != '0) && (r_state[sb.sb_i_rs2] == S_EX) && r_load[sb.sb_i_rs2];
        w_stall = w_use1 || w_use2;
    end

    assign sb.sb_o_stall = w_stall;

    always_comb begin
        w_issue_write = sb.sb_i_issue_valid && !w_stall && !sb.sb_i_stall && !sb.sb_i_flush
                        && sb.sb_i_issue_regwrite && (sb.sb_i_issue_rd != '0);
    end

    // Age every entry one stage; a flush kills EX entries instead of promoting them.
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            w_state_nxt[i] = S_IDLE;
            w_load_nxt[i]  = 1'b0;
            case (r_state[i])
                S_EX:    w_state_nxt[i] = sb.sb_i_flush ? S_IDLE : S_MEM;
                S_MEM:   w_state_nxt[i] = S_WB;
                default: w_state_nxt[i] = S_IDLE;
            endcase
        end
        if (w_issue_write) begin
            w_state_nxt[sb.sb_i_issue_rd] = S_EX;
            w_load_nxt[sb.sb_i_issue_rd]  = sb.sb_i_issue_load;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [AWIDTH-1:0] rs, input state_e st,
                                           input logic ld);
        logic [1:0] sel;
        sel = 2'd0;
        if (rs != '0) begin
            case (st)
                S_EX:    sel = ld ? 2'd0 : 2'd1;
                S_MEM:   sel = 2'd2;
                default: sel = 2'd0;
            endcase
        end
        return sel;
    endfunction

    always_comb begin
        w_ctrl_rs1 = 2'd0;
        w_ctrl_rs2 = 2'd0;
        if (sb.sb_i_issue_valid && !w_stall && !sb.sb_i_flush) begin
            w_ctrl_rs1 = fwd_sel(sb.sb_i_rs1, r_state[sb.sb_i_rs1], r_load[sb.sb_i_rs1]);
            w_ctrl_rs2 = fwd_sel(sb.sb_i_rs2, r_state[sb.sb_i_rs2], r_load[sb.sb_i_rs2]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_state[i] <= S_IDLE;
                r_load[i]  <= 1'b0;
            end
            r_ctrl_rs1 <= 2'd0;
            r_ctrl_rs2 <= 2'd0;
        end else if (!sb.sb_i_stall) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_load[i]  <= w_load_nxt[i];
            end
            r_ctrl_rs1 <= w_ctrl_rs1;
            r_ctrl_rs2 <= w_ctrl_rs2;
        end
    end

    assign sb.sb_o_control_rs1 = r_ctrl_rs1;
    assign sb.sb_o_control_rs2 = r_ctrl_rs2;

    always_comb begin
        sb.sb_o_pending = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            sb.sb_o_pending[i] = (r_state[i] != S_IDLE);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected registered outputs are queued
// when each ID step is driven and compared after the following clock edge.
module tb_hazard_scoreboard;
    localparam int AW = 5;
    localparam int NR = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    typedef struct {
        string       tag;
        logic [1:0]  c1;
        logic [1:0]  c2;
        logic [31:0] pend;
    } exp_t;

    exp_t sbq [$];

    hazard_scoreboard_if #(.AWIDTH(AW), .NREG(NR)) sbif ();

    hazard_scoreboard #(.AWIDTH(AW), .NREG(NR)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one ID-stage cycle, check the combinational stall, then compare the
    // registered outputs popped from the scoreboard after the clock edge.
    task automatic step(input string tag, input logic r, input logic st, input logic fl,
                        input logic v, input logic rw, input logic ld, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic e_stall,
                        input logic [1:0] e1, input logic [1:0] e2, input logic [31:0] epend);
        exp_t e;
        exp_t got;
        rst                      = r;
        sbif.sb_i_stall          = st;
        sbif.sb_i_flush          = fl;
        sbif.sb_i_issue_valid    = v;
        sbif.sb_i_issue_regwrite = rw;
        sbif.sb_i_issue_load     = ld;
        sbif.sb_i_issue_rd       = rd;
        sbif.sb_i_rs1            = rs1;
        sbif.sb_i_rs2            = rs2;
        #1;
        chk({tag, "_stall"}, 32'(sbif.sb_o_stall), 32'(e_stall));
        e.tag = tag; e.c1 = e1; e.c2 = e2; e.pend = epend;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            got = sbq.pop_front();
            chk({got.tag, "_c1"},   32'(sbif.sb_o_control_rs1), 32'(got.c1));
            chk({got.tag, "_c2"},   32'(sbif.sb_o_control_rs2), 32'(got.c2));
            chk({got.tag, "_pend"}, sbif.sb_o_pending,          got.pend);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        sbif.sb_i_stall = 1'b0; sbif.sb_i_flush = 1'b0;
        sbif.sb_i_issue_valid = 1'b0; sbif.sb_i_issue_regwrite = 1'b0;
        sbif.sb_i_issue_load = 1'b0; sbif.sb_i_issue_rd = '0;
        sbif.sb_i_rs1 = '0; sbif.sb_i_rs2 = '0;
        @(posedge clk);
        #1;
        chk("reset_pend",  sbif.sb_o_pending, 32'h0);
        chk("reset_c1",    32'(sbif.sb_o_control_rs1), 32'h0);
        chk("reset_c2",    32'(sbif.sb_o_control_rs2), 32'h0);
        chk("reset_stall", 32'(sbif.sb_o_stall), 32'h0);

        //    tag      rst st fl v  rw ld rd  rs1 rs2  stall c1 c2 pending
        // ALU producer forwarded from EX/MEM, then MEM/WB, then regfile
        step("add_iss", 0, 0, 0, 1, 1, 0, 3,  0,  0,  0, 0, 0, 32'h0000_0008);
        step("add_ex",  0, 0, 0, 1, 0, 0, 0,  3,  0,  0, 1, 0, 32'h0000_0008);
        step("add_mem", 0, 0, 0, 1, 0, 0, 0,  3,  0,  0, 2, 0, 32'h0000_0008);
        step("add_wb",  0, 0, 0, 1, 0, 0, 0,  3,  0,  0, 0, 0, 32'h0000_0000);
        // Load-use: one bubble, then forwarding from MEM/WB
        step("lw_iss",  0, 0, 0, 1, 1, 1, 5,  0,  0,  0, 0, 0, 32'h0000_0020);
        step("lw_use",  0, 0, 0, 1, 0, 0, 0,  0,  5,  1, 0, 0, 32'h0000_0020);
        step("lw_re",   0, 0, 0, 1, 0, 0, 0,  0,  5,  0, 0, 2, 32'h0000_0020);
        step("lw_idle", 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 32'h0000_0000);
        // Back-to-back writers of r7: youngest wins
        step("r7_a",    0, 0, 0, 1, 1, 0, 7,  0,  0,  0, 0, 0, 32'h0000_0080);
        step("r7_b",    0, 0, 0, 1, 1, 0, 7,  0,  0,  0, 0, 0, 32'h0000_0080);
        step("r7_use",  0, 0, 0, 1, 0, 0, 0,  7,  0,  0, 1, 0, 32'h0000_0080);
        step("r7_p1",   0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 32'h0000_0080);
        step("r7_p2",   0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 32'h0000_0000);
        // rd=0 and regwrite=0 are never tracked, even for loads
        step("rd0_ld",  0, 0, 0, 1, 1, 1, 0,  0,  0,  0, 0, 0, 32'h0000_0000);
        step("nowr_ld", 0, 0, 0, 1, 0, 1, 6,  0,  0,  0, 0, 0, 32'h0000_0000);
        step("nowr_rd", 0, 0, 0, 1, 0, 0, 0,  6,  0,  0, 0, 0, 32'h0000_0000);
        // Flush kills a load in EX and the issue presented with it
        step("fl_lw",   0, 0, 0, 1, 1, 1, 4,  0,  0,  0, 0, 0, 32'h0000_0010);
        step("fl_kill", 0, 0, 1, 1, 1, 0, 9,  0,  0,  0, 0, 0, 32'h0000_0000);
        step("fl_use",  0, 0, 0, 1, 0, 0, 0,  4,  0,  0, 0, 0, 32'h0000_0000);
        // External stall freezes everything but stall is still evaluated
        step("st_a",    0, 0, 0, 1, 1, 0, 3,  0,  0,  0, 0, 0, 32'h0000_0008);
        step("st_b",    0, 0, 0, 1, 1, 1, 8,  3,  0,  0, 1, 0, 32'h0000_0108);
        step("st_h1",   0, 1, 1, 1, 1, 0, 10, 0,  8,  1, 1, 0, 32'h0000_0108);
        step("st_h2",   0, 1, 1, 1, 1, 0, 10, 0,  8,  1, 1, 0, 32'h0000_0108);
        step("st_h3",   0, 1, 1, 1, 1, 0, 10, 0,  8,  1, 1, 0, 32'h0000_0108);
        step("st_rel",  0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 32'h0000_0108);
        // Reset with three writers in flight
        step("rs_a",    0, 0, 0, 1, 1, 0, 1,  0,  0,  0, 0, 0, 32'h0000_0102);
        step("rs_b",    0, 0, 0, 1, 1, 0, 2,  0,  0,  0, 0, 0, 32'h0000_0006);
        step("rs_c",    0, 0, 0, 1, 1, 0, 13, 2,  0,  0, 1, 0, 32'h0000_2006);
        step("rs_rst",  1, 0, 0, 1, 1, 0, 14, 13, 0,  0, 0, 0, 32'h0000_0000);
        step("rs_post", 0, 0, 0, 1, 0, 0, 0,  14, 0,  0, 0, 0, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
